hdmi_link_sequencer: RTL and testbench
======================================

// Module: hdmi_link_sequencer
// PURPOSE
//  Brings up and supervises the HDMI TMDS output link in the clk_pixel domain. Holds the
//  serializer in reset until the PLL is locked and a sink is attached, then waits a settle time.
//  It enables video only at a frame boundary, so the sink never sees a partial first frame.
//  On PLL lock loss or unplug it tears the link down and counts the drops.
// PARAMETERS
//  RESET_CYCLES     16     clk_pixel cycles serializer_reset is held in RESET (>=2)
//  SETTLE_CYCLES    1024   cycles after reset release before frame alignment (>=1)
//  DEBOUNCE_CYCLES  65536  consecutive stable cycles required to accept an hpd change (>=1)
// PORTS
//  clk_pixel         in   1  pixel clock; the only clock
//  reset_n           in   1  asynchronous active-low reset
//  pll_locked        in   1  PLL lock, asynchronous; 2-FF synchronized internally -> lock_s
//  hpd               in   1  hot-plug detect, asynchronous; 2-FF sync + debounce -> hpd_db
//  frame_start       in   1  1-cycle pulse on the last pixel of a frame (precedes pixel 0)
//  force_retrain     in   1  1-cycle pulse requesting a serializer re-reset
//  serializer_reset  out  1  active-high reset to the serializer, registered
//  video_enable      out  1  1 = encoder sends video; 0 = encoder sends control/blank only
//  link_up           out  1  1 while in ACTIVE
//  link_state        out  3  current state (link_state_t encoding)
//  drop_count        out  8  saturating count of exits from ACTIVE caused by lock or hpd loss
// BEHAVIOUR
//  Reset: state=IDLE, serializer_reset=1, video_enable=0, link_up=0, drop_count=0, hpd_db=0,
//   sync flops=0, counters=0.
//  All outputs are registered and reflect the state entered on the same edge.
//  Debounce: hpd_db takes the value of hpd_s after hpd_s has differed from hpd_db for
//   DEBOUNCE_CYCLES consecutive cycles. Any return to equality clears the counter.
//  up = lock_s && hpd_db.
//  States and transitions (drop = !up; precedence: drop > force_retrain > normal):
//   IDLE   : serializer_reset=1. up -> RESET, load cnt=RESET_CYCLES-1.
//   RESET  : serializer_reset=1. drop -> IDLE. cnt==0 -> SETTLE, load cnt=SETTLE_CYCLES-1.
//            Otherwise cnt--.
//   SETTLE : serializer_reset=0. drop -> IDLE. retrain -> RESET (reload). cnt==0 -> ALIGN.
//            Otherwise cnt--.
//   ALIGN  : serializer_reset=0. drop -> IDLE. retrain -> RESET. frame_start -> ACTIVE.
//   ACTIVE : serializer_reset=0, video_enable=1, link_up=1. drop -> IDLE and drop_count++
//            (saturates at 255). retrain -> RESET with no count.
//  force_retrain in IDLE or RESET: ignored. A RESET in progress is not restarted.
//  Latency and timing:
//   - video_enable rises on the edge after the frame_start pulse, i.e. coincident with pixel 0.
//   - Any drop clears video_enable/link_up and sets serializer_reset on the next edge.
//   - Minimum time from up to ACTIVE is RESET_CYCLES+SETTLE_CYCLES+1 cycles plus the wait
//     for frame_start.
//  frame_start seen outside ALIGN is ignored.
//  Reset mid-operation: asynchronous return to reset values; no partial-state retention.
//  Counter width is $clog2(max(RESET_CYCLES,SETTLE_CYCLES)); debounce counter width is
//   $clog2(DEBOUNCE_CYCLES+1).
// STRUCTURE
//  hdmi_link_pkg: typedef enum logic[2:0] link_state_t
//   {LINK_IDLE=0, LINK_RESET=1, LINK_SETTLE=2, LINK_ALIGN=3, LINK_ACTIVE=4};
//   also holds the DROP_COUNT_MAX=8'hFF constant.
//  Sub-module hdmi_hpd_debounce (2-FF sync + stable counter, parameter DEBOUNCE_CYCLES).
//   pll_locked synchronizer stays inline.
//  This block contains the FSM, the shared down-counter and the drop counter.
// TESTING (bench uses RESET_CYCLES=4, SETTLE_CYCLES=8, DEBOUNCE_CYCLES=5)
//  1 Bring-up: pll_locked=1, hpd=1, then frame_start 40 cycles later.
//    -> serializer_reset falls exactly 4 cycles after RESET entry; ALIGN after 8 more cycles.
//    -> video_enable=1 one cycle after frame_start; drop_count=0.
//  2 Debounce: hpd glitch high for 4 cycles -> hpd_db stays 0, state IDLE.
//    hpd high for 5+ cycles -> RESET entered.
//  3 Drop in ACTIVE: pll_locked=0 -> after sync, next edge IDLE, serializer_reset=1,
//    video_enable=0, drop_count=1. Repeat 300 drops -> drop_count holds 255.
//  4 Retrain in ACTIVE: force_retrain pulse -> RESET, video_enable=0, drop_count unchanged.
//    Re-aligns at the next frame_start.
//  5 Simultaneous events:
//    - In ALIGN, frame_start and lock loss on the same cycle -> IDLE, not ACTIVE.
//    - In SETTLE, force_retrain and hpd loss on the same cycle -> IDLE.
//  6 Async reset asserted mid-SETTLE -> all outputs at reset values immediately.
//    After release with inputs high -> full sequence restarts from IDLE.

Source files
------------

// File: rtl/hdmi_link_pkg.sv
// hdmi_link_pkg: shared types and constants for the HDMI link sequencer.
//  link_state_t   : sequencer state encoding, also driven out on link_state
//  DROP_COUNT_MAX : saturation value of the drop counter
//  max_int        : helper for sizing the shared down-counter
package hdmi_link_pkg;

  typedef enum logic [2:0] {
    LINK_IDLE   = 3'd0,
    LINK_RESET  = 3'd1,
    LINK_SETTLE = 3'd2,
    LINK_ALIGN  = 3'd3,
    LINK_ACTIVE = 3'd4
  } link_state_t;

  localparam logic [7:0] DROP_COUNT_MAX = 8'hFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hdmi_hpd_debounce.sv
// hdmi_hpd_debounce: 2-FF synchronizer plus stable-time filter for hot-plug detect.
//  clk_pixel  in  pixel clock
//  reset_n    in  asynchronous active-low reset
//  hpd        in  raw hot-plug detect (asynchronous)
//  hpd_db     out debounced hpd; follows the synchronized input only after it has
//                 differed from hpd_db for DEBOUNCE_CYCLES consecutive cycles
module hdmi_hpd_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk_pixel,
  input  logic reset_n,
  input  logic hpd,
  output logic hpd_db
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          hpd_m, hpd_s;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      hpd_m <= 1'b0;
      hpd_s <= 1'b0;
    end else begin
      hpd_m <= hpd;
      hpd_s <= hpd_m;
    end
  end

  // The counter tracks how many consecutive samples hpd_s has disagreed with
  // hpd_db; the last disagreeing sample commits the new level.
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      hpd_db <= 1'b0;
    end else if (hpd_s == hpd_db) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      cnt    <= '0;
      hpd_db <= hpd_s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hdmi_link_sequencer.sv
// hdmi_link_sequencer: brings up and supervises the HDMI TMDS link.
//  clk_pixel         in   pixel clock, the only clock
//  reset_n           in   asynchronous active-low reset
//  pll_locked        in   PLL lock (asynchronous, synchronized here)
//  hpd               in   hot-plug detect (asynchronous, synchronized + debounced)
//  frame_start       in   pulse on the last pixel of a frame
//  force_retrain     in   pulse requesting a serializer re-reset
//  serializer_reset  out  active-high serializer reset
//  video_enable      out  encoder sends video when high
//  link_up           out  high while ACTIVE
//  link_state        out  current link_state_t
//  drop_count        out  saturating count of ACTIVE exits caused by lock/hpd loss
// All outputs are registered from the next state, so they describe the state
// being entered on the same edge.
module hdmi_link_sequencer
  import hdmi_link_pkg::*;
#(
  parameter int RESET_CYCLES    = 16,
  parameter int SETTLE_CYCLES   = 1024,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       hpd,
  input  logic       frame_start,
  input  logic       force_retrain,
  output logic       serializer_reset,
  output logic       video_enable,
  output logic       link_up,
  output logic [2:0] link_state,
  output logic [7:0] drop_count
);

  localparam int MAXC = max_int(RESET_CYCLES, SETTLE_CYCLES);
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] RESET_LOAD  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  logic          lock_m, lock_s;
  logic          hpd_db;
  logic          up;
  link_state_t   state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          drop_inc;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  hdmi_hpd_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hpd_db (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .hpd      (hpd),
    .hpd_db   (hpd_db)
  );

  assign up = lock_s && hpd_db;

  // Loss of up beats retrain, which beats normal progress. Retrain is not
  // decoded in IDLE/RESET so a reset in progress is never restarted.
  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    drop_inc = 1'b0;
    case (state)
      LINK_IDLE: begin
        cnt_nxt = '0;
        if (up) begin
          nxt     = LINK_RESET;
          cnt_nxt = RESET_LOAD;
        end
      end
      LINK_RESET: begin
        if (!up) begin
          nxt = LINK_IDLE;
        end else if (cnt == '0) begin
          nxt     = LINK_SETTLE;
          cnt_nxt = SETTLE_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      LINK_SETTLE: begin
        if (!up) begin
          nxt = LINK_IDLE;
        end else if (force_retrain) begin
          nxt     = LINK_RESET;
          cnt_nxt = RESET_LOAD;
        end else if (cnt == '0) begin
          nxt = LINK_ALIGN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      LINK_ALIGN: begin
        if (!up) begin
          nxt = LINK_IDLE;
        end else if (force_retrain) begin
          nxt     = LINK_RESET;
          cnt_nxt = RESET_LOAD;
        end else if (frame_start) begin
          nxt = LINK_ACTIVE;
        end
      end
      LINK_ACTIVE: begin
        if (!up) begin
          nxt      = LINK_IDLE;
          drop_inc = 1'b1;
        end else if (force_retrain) begin
          nxt     = LINK_RESET;
          cnt_nxt = RESET_LOAD;
        end
      end
      default: begin
        nxt     = LINK_IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state            <= LINK_IDLE;
      cnt              <= '0;
      serializer_reset <= 1'b1;
      video_enable     <= 1'b0;
      link_up          <= 1'b0;
    end else begin
      state            <= nxt;
      cnt              <= cnt_nxt;
      serializer_reset <= (nxt == LINK_IDLE) || (nxt == LINK_RESET);
      video_enable     <= (nxt == LINK_ACTIVE);
      link_up          <= (nxt == LINK_ACTIVE);
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop_inc && (drop_count != DROP_COUNT_MAX)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  assign link_state = state;

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Directed bench for hdmi_link_sequencer (RESET=4, SETTLE=8, DEBOUNCE=5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_hdmi_link_sequencer;
  import hdmi_link_pkg::*;

  logic       clk_pixel = 1'b0;
  logic       reset_n, pll_locked, hpd, frame_start, force_retrain;
  logic       serializer_reset, video_enable, link_up;
  logic [2:0] link_state;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_link_sequencer #(
    .RESET_CYCLES(4), .SETTLE_CYCLES(8), .DEBOUNCE_CYCLES(5)
  ) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .pll_locked(pll_locked), .hpd(hpd),
    .frame_start(frame_start), .force_retrain(force_retrain),
    .serializer_reset(serializer_reset), .video_enable(video_enable),
    .link_up(link_up), .link_state(link_state), .drop_count(drop_count)
  );

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  // Bounded wait for a state; a timeout is recorded as a failed check.
  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (link_state !== target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (link_state !== target) begin
      errors++;
      $display("FAIL %s timeout: state %0d, wanted %0d", tag, link_state, target);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({link_state, serializer_reset, video_enable, link_up, drop_count} !==
        {LINK_IDLE, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values: st=%0d srst=%b ven=%b up=%b drops=%0d",
               link_state, serializer_reset, video_enable, link_up, drop_count);
    end
  endtask

  task automatic test_debounce();
    pll_locked = 1'b1;
    hpd = 1'b1;
    repeat (4) tick();
    hpd = 1'b0;
    repeat (12) tick();
    checks++;
    if (link_state !== LINK_IDLE || serializer_reset !== 1'b1) begin
      errors++;
      $display("FAIL hpd_glitch: st=%0d srst=%b, wanted IDLE/1", link_state, serializer_reset);
    end
    // 2 sync cycles + 5 stable samples, then the FSM reacts on the next edge.
    hpd = 1'b1;
    repeat (7) tick();
    checks++;
    if (link_state !== LINK_IDLE) begin
      errors++;
      $display("FAIL hpd_early: st=%0d, wanted %0d", link_state, LINK_IDLE);
    end
    tick();
    checks++;
    if (link_state !== LINK_RESET || serializer_reset !== 1'b1) begin
      errors++;
      $display("FAIL hpd_accept: st=%0d srst=%b, wanted RESET/1", link_state, serializer_reset);
    end
  endtask

  task automatic test_bringup();
    repeat (3) tick();
    checks++;
    if (link_state !== LINK_RESET || serializer_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: st=%0d srst=%b, wanted RESET/1", link_state, serializer_reset);
    end
    tick();
    checks++;
    if (link_state !== LINK_SETTLE || serializer_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: st=%0d srst=%b, wanted SETTLE/0", link_state, serializer_reset);
    end
    frame_start = 1'b1;  // ignored outside ALIGN
    tick();
    frame_start = 1'b0;
    repeat (6) tick();
    checks++;
    if (link_state !== LINK_SETTLE) begin
      errors++;
      $display("FAIL settle_hold: st=%0d, wanted %0d", link_state, LINK_SETTLE);
    end
    tick();
    checks++;
    if (link_state !== LINK_ALIGN) begin
      errors++;
      $display("FAIL align_entry: st=%0d, wanted %0d", link_state, LINK_ALIGN);
    end
    repeat (40) tick();
    checks++;
    if (link_state !== LINK_ALIGN || video_enable !== 1'b0 || link_up !== 1'b0) begin
      errors++;
      $display("FAIL align_wait: st=%0d ven=%b up=%b", link_state, video_enable, link_up);
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if ({link_state, video_enable, link_up, serializer_reset, drop_count} !==
        {LINK_ACTIVE, 1'b1, 1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL go_active: st=%0d ven=%b up=%b srst=%b drops=%0d",
               link_state, video_enable, link_up, serializer_reset, drop_count);
    end
  endtask

  task automatic test_retrain();
    force_retrain = 1'b1;
    tick();
    force_retrain = 1'b0;
    checks++;
    if ({link_state, video_enable, link_up, serializer_reset, drop_count} !==
        {LINK_RESET, 1'b0, 1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL retrain_active: st=%0d ven=%b up=%b srst=%b drops=%0d",
               link_state, video_enable, link_up, serializer_reset, drop_count);
    end
    tick();
    force_retrain = 1'b1;  // must not restart the RESET countdown
    tick();
    force_retrain = 1'b0;
    repeat (2) tick();
    checks++;
    if (link_state !== LINK_SETTLE) begin
      errors++;
      $display("FAIL retrain_in_reset: st=%0d, wanted %0d", link_state, LINK_SETTLE);
    end
    wait_state(LINK_ALIGN, 20, "realign");
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++;
    if (link_state !== LINK_ACTIVE || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL retrain_reactive: st=%0d drops=%0d", link_state, drop_count);
    end
  endtask

  task automatic test_drop();
    int exp_drops = 0;
    pll_locked = 1'b0;
    repeat (2) tick();
    checks++;
    if (link_state !== LINK_ACTIVE) begin
      errors++;
      $display("FAIL drop_sync_delay: st=%0d, wanted %0d", link_state, LINK_ACTIVE);
    end
    tick();
    exp_drops = 1;
    checks++;
    if ({link_state, serializer_reset, video_enable, link_up, drop_count} !==
        {LINK_IDLE, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL drop_first: st=%0d srst=%b ven=%b up=%b drops=%0d",
               link_state, serializer_reset, video_enable, link_up, drop_count);
    end
    for (int i = 1; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_state(LINK_ALIGN, 40, "drop_loop_align");
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      pll_locked = 1'b0;
      repeat (3) tick();
      exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
      checks++;
      if (drop_count !== 8'(exp_drops) || link_state !== LINK_IDLE) begin
        errors++;
        $display("FAIL drop_count_%0d: got %0d st=%0d, wanted %0d IDLE",
                 i, drop_count, link_state, exp_drops);
      end
    end
  endtask

  task automatic test_simultaneous();
    pll_locked = 1'b1;
    wait_state(LINK_ALIGN, 40, "sim_align");
    pll_locked = 1'b0;
    repeat (2) tick();
    checks++;
    if (link_state !== LINK_ALIGN) begin
      errors++;
      $display("FAIL sim_pre: st=%0d, wanted %0d", link_state, LINK_ALIGN);
    end
    frame_start = 1'b1;  // lands on the same edge the lock loss is seen
    tick();
    frame_start = 1'b0;
    checks++;
    if (link_state !== LINK_IDLE || video_enable !== 1'b0 || drop_count !== 8'd255) begin
      errors++;
      $display("FAIL frame_vs_drop: st=%0d ven=%b drops=%0d", link_state, video_enable, drop_count);
    end
    pll_locked = 1'b1;
    wait_state(LINK_RESET, 20, "sim_reset");
    hpd = 1'b0;  // debounced loss reaches the FSM 8 edges later, in SETTLE
    repeat (7) tick();
    checks++;
    if (link_state !== LINK_SETTLE) begin
      errors++;
      $display("FAIL sim_settle: st=%0d, wanted %0d", link_state, LINK_SETTLE);
    end
    force_retrain = 1'b1;
    tick();
    force_retrain = 1'b0;
    checks++;
    if (link_state !== LINK_IDLE || serializer_reset !== 1'b1) begin
      errors++;
      $display("FAIL retrain_vs_drop: st=%0d srst=%b, wanted IDLE/1", link_state, serializer_reset);
    end
    hpd = 1'b1;
  endtask

  task automatic test_async_reset();
    wait_state(LINK_SETTLE, 40, "ar_settle");
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({link_state, serializer_reset, video_enable, link_up, drop_count} !==
        {LINK_IDLE, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: st=%0d srst=%b ven=%b up=%b drops=%0d",
               link_state, serializer_reset, video_enable, link_up, drop_count);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (7) tick();
    checks++;
    if (link_state !== LINK_IDLE) begin
      errors++;
      $display("FAIL restart_idle: st=%0d, wanted %0d", link_state, LINK_IDLE);
    end
    tick();
    checks++;
    if (link_state !== LINK_RESET) begin
      errors++;
      $display("FAIL restart_reset: st=%0d, wanted %0d", link_state, LINK_RESET);
    end
    repeat (12) tick();
    checks++;
    if (link_state !== LINK_ALIGN || serializer_reset !== 1'b0) begin
      errors++;
      $display("FAIL restart_align: st=%0d srst=%b", link_state, serializer_reset);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    pll_locked    = 1'b0;
    hpd           = 1'b0;
    frame_start   = 1'b0;
    force_retrain = 1'b0;
    repeat (3) tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_debounce();
    test_bringup();
    test_retrain();
    test_drop();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
